// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the multi-cycle data-memory responder.
//   - state_t    : responder FSM states (IDLE, BUSY, DONE)
//   - WORD_W     : data word width (32)
//   - word_index : byte address -> word index, wrapped modulo the array depth
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index of a byte address. depth is a power of two, so masking the
    // word address wraps it modulo depth; upper address bits are discarded.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                     input int unsigned       depth);
        return (addr >> 2) & WORD_W'(depth - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x WORD_W storage with synchronous write and registered read.
// Both ports are used only in the commit cycle of the responder. A read and a
// write to the same word in one cycle return the pre-write contents.
// The array and the read register are not reset so the storage maps onto
// block RAM.
// Ports:
//   clk    in   clock
//   rd_en  in   capture mem[idx] into rdata
//   wr_en  in   write wdata into mem[idx]
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data (holds while rd_en=0)
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline.
// A load/store request is accepted in IDLE, the pipeline is held with stall_o
// for LATENCY BUSY cycles, the access commits on the BUSY->DONE edge and DONE
// presents a one-cycle valid_o pulse with the read data / error flag.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  BUSY cycles per access (>= 1)
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   memRead_i    in   load request (held stable while stall_o=1)
//   memWrite_i   in   store request (held stable while stall_o=1)
//   addr_i       in   byte address
//   WriteData_i  in   store data
//   ReadData_o   out  load data, meaningful while valid_o=1, holds otherwise
//   valid_o      out  one-cycle access-complete pulse
//   err_o        out  misaligned access, qualified by valid_o
//   stall_o      out  pipeline freeze
//
// Optional feature (macro DMEM_PERF_EN):
//   rd_cnt_o     out  number of committed aligned reads (wraps at 2^32)
//   wr_cnt_o     out  number of committed aligned writes (wraps at 2^32)
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] WriteData_i,
    output logic [WORD_W-1:0] ReadData_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              stall_o
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_reg;
    state_t             state_next;

    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WORD_W-1:0]  wdata_reg;
    logic               rd_reg;
    logic               wr_reg;
    logic               mis_reg;
    logic               err_reg;
    // Forces ReadData_o to zero after reset and after a misaligned access;
    // cleared when an aligned read refreshes the array's read register.
    logic               zero_reg;

    logic               req;
    logic               accept;
    logic               commit;
    logic               arr_rd_en;
    logic               arr_wr_en;
    logic [WORD_W-1:0]  arr_rdata;

    assign req       = memRead_i | memWrite_i;
    assign arr_rd_en = commit & rd_reg & ~mis_reg;
    assign arr_wr_en = commit & wr_reg & ~mis_reg;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt_reg == '0) state_next = DONE;
            // The request still present in DONE is the one just served.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_o = 1'b0;
        valid_o = 1'b0;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_o = req;
                accept  = req;
            end
            BUSY: begin
                stall_o = 1'b1;
                commit  = (cnt_reg == '0);
            end
            DONE: begin
                valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o      = valid_o & err_reg;
    assign ReadData_o = zero_reg ? '0 : arr_rdata;

    // ---------------- Request latches, latency counter, result flags ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            mis_reg   <= 1'b0;
            err_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            if (accept) begin
                cnt_reg   <= CNT_W'(LATENCY - 1);
                idx_reg   <= IDX_W'(word_index(addr_i, DEPTH));
                wdata_reg <= WriteData_i;
                rd_reg    <= memRead_i;
                wr_reg    <= memWrite_i;
                mis_reg   <= (addr_i[1:0] != 2'b00);
            end else if (state_reg == BUSY && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end

            if (commit) begin
                err_reg <= mis_reg;
                if (mis_reg) begin
                    zero_reg <= 1'b1;
                end else if (rd_reg) begin
                    zero_reg <= 1'b0;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .rd_en (arr_rd_en),
        .wr_en (arr_wr_en),
        .idx   (idx_reg),
        .wdata (wdata_reg),
        .rdata (arr_rdata)
    );

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            if (arr_rd_en) rd_cnt_o <= rd_cnt_o + 32'd1;
            if (arr_wr_en) wr_cnt_o <= wr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (DEPTH=32, LATENCY=2). A word-array
// reference model predicts read data, error flag, stall length and (with
// DMEM_PERF_EN) the access counters. Directed scenarios are followed by a
// randomized access sequence.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        valid;
    logic        err;
    logic        stall;
`ifdef DMEM_PERF_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .memRead_i   (mem_read),
        .memWrite_i  (mem_write),
        .addr_i      (addr),
        .WriteData_i (wdata),
        .ReadData_o  (rdata),
        .valid_o     (valid),
        .err_o       (err),
        .stall_o     (stall)
`ifdef DMEM_PERF_EN
        ,
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    int unsigned model_rd_cnt;
    int unsigned model_wr_cnt;

    int n_cmp;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One access: called shortly after a rising edge with the responder idle.
    // The request is held until the DONE cycle ends, then dropped.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int  idx;
        bit  mis;
        int  stalls;
        bit  seen;
        idx = int'((a / 4) % DEPTH);
        mis = (a % 4) != 0;
        if (mis) begin
            model_rdata = 32'h0;
        end else begin
            if (rd) begin
                model_rdata = model_mem[idx];
                model_rd_cnt++;
            end
            if (wr) begin
                model_mem[idx] = wd;
                model_wr_cnt++;
            end
        end

        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        stalls    = 0;
        seen      = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
            else if (stall) stalls++;
        end
        check_eq("valid_pulse", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("rdata", rdata, model_rdata);
            check_eq("err", 32'(err), 32'(mis));
            check_eq("stall_in_done", 32'(stall), 32'd0);
            check_eq("stall_cycles", 32'(stalls), 32'(LAT + 1));
`ifdef DMEM_PERF_EN
            check_eq("rd_cnt", rd_cnt, model_rd_cnt);
            check_eq("wr_cnt", wr_cnt, model_wr_cnt);
`endif
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        // Served request must not be re-accepted after DONE.
        check_eq("no_reaccept_valid", 32'(valid), 32'd0);
        check_eq("no_reaccept_stall", 32'(stall), 32'd0);
        $display("txn rd=%0d wr=%0d addr=%08h wdata=%08h rdata=%08h err=%0d stalls=%0d",
                 rd, wr, a, wd, rdata, err, stalls);
    endtask

    initial begin
        logic [31:0] old_c;
        logic [31:0] ra;
        logic [1:0]  op;

        n_cmp        = 0;
        n_err        = 0;
        model_rdata  = 32'h0;
        model_rd_cnt = 0;
        model_wr_cnt = 0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr         = 32'h0;
        wdata        = 32'h0;
        rst_n        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_stall_idle", 32'(stall), 32'd0);
        mem_read = 1'b1;
        #1;
        check_eq("rst_stall_follows_req", 32'(stall), 32'd1);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), $urandom);
        end

        // Write then read 0x10
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        check_eq("t1_read_10", rdata, 32'hDEADBEEF);

        // Read+write together returns pre-write data
        access(1'b0, 1'b1, 32'h04, 32'h11);
        access(1'b1, 1'b1, 32'h04, 32'h22);
        check_eq("t2_rw_old", rdata, 32'h11);
        access(1'b1, 1'b0, 32'h04, 32'h0);
        check_eq("t2_read_new", rdata, 32'h22);

        // Misaligned read, then misaligned write must not disturb memory
        access(1'b1, 1'b0, 32'h06, 32'h0);
        check_eq("t3_mis_rdata", rdata, 32'h0);
        access(1'b0, 1'b1, 32'h05, 32'hBAD0BAD0);
        access(1'b1, 1'b0, 32'h04, 32'h0);
        check_eq("t3_mem_unchanged", rdata, 32'h22);

        // Address wrap modulo DEPTH
        access(1'b0, 1'b1, 32'(4 * DEPTH + 8), 32'h5A5A);
        access(1'b1, 1'b0, 32'h08, 32'h0);
        check_eq("t4_wrap", rdata, 32'h5A5A);

        // Reset during BUSY of a write: write dropped
        old_c     = model_mem[3];
        mem_write = 1'b1;
        addr      = 32'h0C;
        wdata     = 32'h77;
        @(posedge clk);
        #2;
        check_eq("t5_busy_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_rdata", rdata, 32'h0);
        check_eq("t5_rst_valid", 32'(valid), 32'd0);
        check_eq("t5_rst_err", 32'(err), 32'd0);
        check_eq("t5_rst_stall_req", 32'(stall), 32'd1);
        mem_write = 1'b0;
        #1;
        check_eq("t5_rst_stall_noreq", 32'(stall), 32'd0);
        model_rdata  = 32'h0;
        model_rd_cnt = 0;
        model_wr_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h0C, 32'h0);
        check_eq("t5_old_value", rdata, old_c);

        // Back-to-back loads
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, 32'(i * 4), 32'h0);
        end

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
            op = 2'($urandom_range(1, 3));
            access(op[0], op[1], ra, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
